// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier core.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Map a {y[2i+1], y[2i], y[2i-1]} triplet to its Booth digit.
    function automatic digit_t booth_decode(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: one digit times x, placed at weight 4^cnt.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic [2:0]         bits,
    input  logic [WIDTH-1:0]   x,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] pp
);

    digit_t             digit;
    logic [2*WIDTH-1:0] x_ext;
    logic [2*WIDTH-1:0] mag;

    // Select 0/x/2x, negate as invert-plus-one so the adder sees a complete two's complement term.
    always_comb begin
        digit = booth_decode(bits);
        x_ext = {{WIDTH{x[WIDTH-1]}}, x};
        mag   = '0;
        case (digit)
            POS1, NEG1: mag = x_ext;
            POS2, NEG2: mag = x_ext << 1;
            default:    mag = '0;
        endcase
        if (digit == NEG1 || digit == NEG2) begin
            mag = ~mag + 1'b1;
        end
        pp = mag << {cnt, 1'b0};
    end

endmodule

// File: rtl/cla_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups; W must be a multiple of 4.
module cla_adder #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    logic       carry;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    // Per group: local generate/propagate, fully expanded carries, group carry-out.
    always_comb begin
        sum   = '0;
        carry = cin;
        g     = '0;
        p     = '0;
        cc    = '0;
        for (int i = 0; i < W / 4; i++) begin
            g     = a[4*i +: 4] & b[4*i +: 4];
            p     = a[4*i +: 4] ^ b[4*i +: 4];
            cc[0] = carry;
            cc[1] = g[0] | (p[0] & carry);
            cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
            cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & carry);
            cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & carry);
            sum[4*i +: 4] = p ^ cc[3:0];
            carry = cc[4];
        end
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, accumulated through the CLA.
// Optional build macro BOOTH_EARLY_TERM_EN finishes as soon as the remaining multiplier digits are all zero.
// Reset is asserted asynchronously; its release is expected to be synchronized upstream.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int NDIG  = WIDTH / 2;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int PW    = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       digit_bits;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    sum;
    logic             last_digit;

    // Pick the current Booth triplet; y[-1] is the appended zero below bit 0.
    always_comb begin
        digit_bits = 3'({y_q, 1'b0} >> {cnt_q, 1'b0});
    end

    booth_pp_gen #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_pp_gen (
        .bits (digit_bits),
        .x    (x_q),
        .cnt  (cnt_q),
        .pp   (pp)
    );

    cla_adder #(
        .W (PW)
    ) u_cla (
        .a   (acc_q),
        .b   (pp),
        .cin (1'b0),
        .sum (sum)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH-1:0] y_rest;

    // Stop once the bits above the current digit are pure sign extension: all later digits are zero.
    always_comb begin
        y_rest     = $signed(y_q) >>> ({cnt_q, 1'b0} + 1'b1);
        last_digit = (cnt_q == CNT_W'(NDIG - 1)) || (y_rest == '0) || (y_rest == '1);
    end
`else
    // Fixed-length run: the final digit is always digit NDIG-1.
    always_comb begin
        last_digit = (cnt_q == CNT_W'(NDIG - 1));
    end
`endif

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = acc_q;

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Sequential radix-4 Booth multiplier core for signed WIDTH x WIDTH operands.
- Recodes the multiplier one Booth digit per cycle and forms the partial product.
- Accumulates each partial product through the team's 24-bit carry-lookahead adder (cin tied 0).
- Sits upstream of the adder: it generates and feeds every partial-product addition, then presents the 2*WIDTH product on a valid/ready output.

Parameters:
- WIDTH, 12, operand width in bits; must be even; product width is 2*WIDTH.
- NDIG, WIDTH/2, Booth digit count; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  core can accept operands; high only in IDLE
- x_in  in  WIDTH  multiplicand, two's complement
- y_in  in  WIDTH  multiplier, two's complement
- out_valid  out  1  product valid; high only in DONE
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  signed product
- busy  out  1  high in RUN

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, acc=0, cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, on in_valid&&in_ready at edge E0:
  - latch x_in and y_in;
  - acc<=0, cnt<=0;
  - go RUN. in_valid while not in IDLE is ignored; no queueing.
- RUN, each edge:
  - digit d(cnt) from {y[2cnt+1], y[2cnt], y[2cnt-1]}, with y[-1]=0. Mapping: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  - pp = d*x, sign-extended to 2*WIDTH, shifted left by 2*cnt. Negative digits are formed as invert plus 1, with the +1 folded into pp before the adder.
  - acc <= acc + pp, modulo 2^(2*WIDTH).
  - cnt++. When cnt==NDIG-1 on this edge, go DONE.
- Latency: exactly NDIG RUN edges, so out_valid rises after edge E0+NDIG (6 cycles at default). busy is high for exactly NDIG cycles.
- DONE:
  - product = acc, registered and stable while out_valid=1 && out_ready=0;
  - on out_valid&&out_ready go IDLE; in_ready rises the following cycle;
  - no same-cycle accept of new operands.
- Result is exact over the full signed range, e.g. (-2^(W-1))^2 = 2^(2W-2) fits. No overflow flag.
- out_ready high before DONE has no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: after processing digit cnt, if y[WIDTH-1 : 2cnt+1] are all equal, every remaining digit is 0. The core goes DONE on that edge, so RUN lasts 1..NDIG cycles. The product value is unchanged.
- Undefined: fixed NDIG-cycle RUN. The comparison logic is absent.

Decomposition:
- Shared package booth_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2);
  - default WIDTH.
- One sub-module: booth_pp_gen. It is combinational: 3 multiplier bits plus x plus cnt in, shifted 2*WIDTH partial product out.
- Accumulation reuses the existing 24-bit CLA instance. FSM, counter and registers stay in booth_seq_mult.

Test Plan:
- x=3, y=5 -> product=0x00000F; out_valid exactly 6 cycles after accept; busy high 6 cycles.
- x=-2048, y=-2048 -> 0x400000. x=2047, y=-2048 -> 0xC00800. x=-1, y=1 -> 0xFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 at RUN cycle 3 of x=100, y=-7 -> all outputs return to reset values immediately; the next op x=-7, y=100 gives 0xFFFD44 (-700) with no stale data.
- Random 10k signed pairs with random in_valid/out_ready gaps -> product == x*y, checked against a scoreboard; exactly one result per accepted operand pair.
- BOOTH_EARLY_TERM_EN defined, x=9, y=1 -> product=9 after 1 RUN cycle; y=0x7FF -> 6 cycles; undefined -> always 6 cycles.
